// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX FIFO write port between two byte
// producers (0: CPU console MMIO, 1: debug monitor). A granted requester keeps
// the port until it writes LF or its valid stays low for TIMEOUT cycles, so
// lines from the two sources never interleave in the FIFO.
// Ports:
//   clk, RESET                 clock / async active-low reset
//   req_valid[1:0]             per-requester byte valid
//   req_data0, req_data1       per-requester byte
//   req_ready[1:0]             per-requester accept (combinational)
//   fifo_full                  FIFO full flag
//   fifo_write, fifo_data      FIFO write strobe / data (combinational)
//   owner[1:0]                 one-hot lock holder, 00 when idle (registered)
//   bytes0, bytes1             saturating accepted-byte counters
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  output logic [1:0]       req_ready,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [7:0]       fifo_data,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] bytes0,
  output logic [CNT_W-1:0] bytes1
);

  localparam int unsigned IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [7:0]        LF        = 8'h0A;

  // Lock encodings double as the one-hot owner value.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_LOCK0 = 2'b01;
  localparam logic [1:0] S_LOCK1 = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  bytes0_q, bytes0_d;
  logic [CNT_W-1:0]  bytes1_q, bytes1_d;

  logic              own_sel;
  logic              cur_valid;
  logic [7:0]        cur_data;
  logic              accept;

  // Next-state, counters and combinational FIFO-side outputs.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idle_d     = idle_q;
    bytes0_d   = bytes0_q;
    bytes1_d   = bytes1_q;
    req_ready  = 2'b00;
    fifo_write = 1'b0;
    fifo_data  = 8'h00;
    own_sel    = (state_q == S_LOCK1);
    cur_valid  = own_sel ? req_valid[1] : req_valid[0];
    cur_data   = own_sel ? req_data1 : req_data0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Arbitration bubble; idle_q is zero on entry to any lock.
        idle_d = '0;
        if (req_valid == 2'b11) begin
          state_d = last_q ? S_LOCK0 : S_LOCK1;
        end else if (req_valid[0]) begin
          state_d = S_LOCK0;
        end else if (req_valid[1]) begin
          state_d = S_LOCK1;
        end
      end
      S_LOCK0, S_LOCK1: begin
        req_ready  = own_sel ? {~fifo_full, 1'b0} : {1'b0, ~fifo_full};
        accept     = cur_valid & ~fifo_full;
        fifo_write = accept;
        fifo_data  = accept ? cur_data : 8'h00;
        if (accept) begin
          idle_d = '0;
          if (own_sel) begin
            if (bytes1_q != CNT_MAX) bytes1_d = bytes1_q + CNT_W'(1);
          end else begin
            if (bytes0_q != CNT_MAX) bytes0_d = bytes0_q + CNT_W'(1);
          end
          if (cur_data == LF) begin
            state_d = S_IDLE;
            last_d  = own_sel;
          end
        end else if (!cur_valid) begin
          // Only true idleness counts; full-FIFO stalls hold the counter.
          if ((TIMEOUT != 0) && (idle_q == IDLE_LAST)) begin
            state_d = S_IDLE;
            last_d  = own_sel;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      idle_q   <= '0;
      bytes0_q <= '0;
      bytes1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idle_q   <= idle_d;
      bytes0_q <= bytes0_d;
      bytes1_q <= bytes1_d;
    end
  end

  assign owner  = state_q;
  assign bytes0 = bytes0_q;
  assign bytes1 = bytes1_q;

endmodule
